// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, data width, default bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;   // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset value 1 (idle line).
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling.
// Latency: rx_valid / rx_frame_err pulse 1 clk after the stop-bit sample cycle.
// Backpressure: none; rx_data holds until the next good frame, pulses are not held.
// Ports: clk, rst (async active-high), fpag_uart_rx (serial in, idle high),
//        rx_data[7:0], rx_valid, rx_frame_err, rx_busy, rx_parity_err (macro only).
// Macro: UART_RX_PARITY_EN enables the even-parity bit and the rx_parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fpag_uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 rx_parity_err
`endif
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t          state_q, state_n;
    logic [15:0]          cnt_q, cnt_n;
    logic [2:0]           bit_idx_q, bit_idx_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n;
    logic                 line_s, line_prev;
    logic [1:0]           settle_q;
    logic                 armed_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_n, perr_n;
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (fpag_uart_rx),
        .q   (line_s)
    );

    // The synchronizer comes out of reset showing 1 regardless of the real
    // line, so a line held low through reset would look like a falling edge.
    // Start detection is armed only once the synchronizer has flushed and the
    // line has genuinely been seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && line_s) armed_q <= 1'b1;
            line_prev <= line_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q         <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            bit_idx_q    <= bit_idx_n;
            shift_q      <= shift_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q         <= par_n;
            rx_parity_err <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_idx_n = bit_idx_q;
        shift_n   = shift_q;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n     = par_q;
        perr_n    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (armed_q && line_prev && !line_s) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    if (!line_s) begin
                        state_n   = DATA;
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_n = {line_s, shift_q[DATA_BITS-1:1]};
                    cnt_n   = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == 16'd0) begin
                    par_n   = line_s;
                    cnt_n   = FULL_LOAD;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (line_s) begin
                        data_n  = shift_q;
                        valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit must XOR to 0.
                        perr_n  = ^{shift_q, par_q};
`endif
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
            WAIT_HIGH: begin
                // Break or stuck-low line: stay here until it recovers.
                if (line_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = 171;
`else
    localparam int EXP_LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .fpag_uart_rx (line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int perr_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) valid_cnt++;
            if (rx_frame_err) ferr_cnt++;
            if (rx_valid && rx_frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
            if (rx_parity_err) perr_cnt++;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic drive_bit(input logic b);
        line = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d, input logic p);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(1'b1);
    endtask
`endif

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        int         gap_bits;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int v0, f0, lat, got;

        vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};   // 0x00 then 0xFF, no gap
        vecs[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
        vecs[3] = '{8'h99, 1'b0, 2, 0, 1, 8'hFF};   // bad stop, data holds
        vecs[4] = '{8'h81, 1'b1, 0, 1, 0, 8'h81};
        vecs[5] = '{8'h7E, 1'b1, 1, 1, 0, 8'h7E};
        vecs[6] = '{8'h01, 1'b1, 2, 1, 0, 8'h01};

        // Reset values, with the line already low through reset.
        rst  = 1'b1;
        line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        rst = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        check("low_after_reset_busy", rx_busy, 0);
        check("low_after_reset_valid_cnt", valid_cnt, 0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].d, vecs[i].stop_b);
            check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_v);
            check($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, vecs[i].exp_f);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            if (vecs[i].stop_b) check($sformatf("vec%0d_busy_after_stop", i), rx_busy, 0);
            for (int g = 0; g < vecs[i].gap_bits; g++) drive_bit(1'b1);
        end

        // Exact latency from start-bit edge to rx_valid.
        lat = 0;
        got = 0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int c = 1; c <= 400 && got == 0; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (rx_valid) begin
                        got = 1;
                        lat = c;
                    end
                end
            end
        join
        check("latency_cycles", lat, EXP_LAT);
        check("latency_rx_data", rx_data, 8'h5A);
        drive_bit(1'b1);

        // 5-cycle glitch on idle line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        line = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy_in_start", rx_busy, 1);
        line = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("glitch_busy_after", rx_busy, 0);
        check("glitch_valid_pulses", valid_cnt - v0, 0);
        check("glitch_ferr_pulses", ferr_cnt - f0, 0);
        check("glitch_rx_data", rx_data, 8'h5A);

        // Frame error followed by a 40-bit break.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        for (int b = 0; b < 40; b++) drive_bit(1'b0);
        check("break_busy_held", rx_busy, 1);
        check("break_ferr_pulses", ferr_cnt - f0, 1);
        check("break_valid_pulses", valid_cnt - v0, 0);
        check("break_rx_data", rx_data, 8'h5A);
        drive_bit(1'b1);
        check("break_busy_released", rx_busy, 0);
        send_frame(8'h3C, 1'b1);
        check("after_break_rx_data", rx_data, 8'h3C);
        check("after_break_valid_pulses", valid_cnt - v0, 1);
        drive_bit(1'b1);

        // Reset during data bit 4 of 0x55.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        line = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_frame_err", rx_frame_err, 0);
        check("midreset_rx_busy", rx_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("midreset_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h12, 1'b1);
        check("post_reset_rx_data", rx_data, 8'h12);
        check("post_reset_valid_pulses", valid_cnt - v0, 1);
        drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        f0 = perr_cnt;
        send_frame_p(8'h07, 1'b0);
        check("parity_bad_rx_data", rx_data, 8'h07);
        check("parity_bad_perr_pulses", perr_cnt - f0, 1);
        drive_bit(1'b1);
        f0 = perr_cnt;
        send_frame_p(8'h07, 1'b1);
        check("parity_good_perr_pulses", perr_cnt - f0, 0);
        drive_bit(1'b1);
`endif

        check("valid_and_ferr_together", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
